blockfifo_ctrl: RTL and testbench

Sequencer for one block FIFO instance. It runs fill/drain/clear cycles:
- Gates upstream writes into the FIFO until a block is complete, or until a flush is requested.
- Walks the FIFO read pointer to stream the block out over a valid/ready interface.
- Pulses the FIFO's clear so the next block can fill.
It sits between the upstream producer, the block FIFO and the downstream consumer.

---
 rtl/blockfifo_pkg.sv | 35 +++
 rtl/blockfifo_ctrl.sv | 147 ++++++++++++++
 tb/tb_blockfifo_ctrl.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/blockfifo_pkg.sv
// ============================================================================
// Module      : blockfifo_pkg
// Description : Shared types and constants for the block FIFO sequencer:
//               FSM state encoding, default geometry and the read-pointer
//               width helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package blockfifo_pkg;

  // Default block geometry: LEN words of WID bits each.
  localparam int DEF_LEN = 8;
  localparam int DEF_WID = 8;

  // Sequencer states. The 2-bit encoding is fixed so downstream debug
  // tooling can decode the state register directly.
  typedef enum logic [1:0] {
    FILL  = 2'd0,
    DRAIN = 2'd1,
    CLEAR = 2'd2
  } state_t;

  // Read-pointer width for a block of len words. It is clamped to at least
  // one bit so that a degenerate one-word block still yields a legal vector.
  function automatic int addr_w(input int len);
    if (len <= 2) begin
      return 1;
    end
    return $clog2(len);
  endfunction

endpackage : blockfifo_pkg

`default_nettype wire

// File: rtl/blockfifo_ctrl.sv
// ============================================================================
// Module      : blockfifo_ctrl
// Description : Fill/drain/clear sequencer for a single block FIFO. Gates
//               upstream writes until a block is complete (or flushed),
//               streams the block out over valid/ready by walking the FIFO
//               read pointer, then pulses the FIFO clear for one cycle.
//               Optional feature macro: BLKCTRL_LAST_EN adds the out_last
//               output marking the final beat of each block.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module blockfifo_ctrl
  import blockfifo_pkg::*;
#(
  parameter int LEN    = DEF_LEN,
  parameter int WID    = DEF_WID,
  parameter int ADDR_W = addr_w(LEN)
) (
  input  logic              clk,
  input  logic              reset,
  // Upstream producer
  input  logic              in_write,
  input  logic [WID-1:0]    in_data,
  output logic              in_ready,
  input  logic              flush_req,
  // Block FIFO
  output logic              fifo_write,
  output logic [WID-1:0]    fifo_data_i,
  input  logic              fifo_ready,
  output logic              fifo_clr,
  output logic [ADDR_W-1:0] fifo_read_ptr,
  input  logic [WID-1:0]    fifo_data_o,
  // Downstream consumer
  output logic [WID-1:0]    out_data,
  output logic              out_valid,
  input  logic              out_ready,
  // Status
  output logic              busy,
  output logic              block_done
`ifdef BLKCTRL_LAST_EN
  ,
  output logic              out_last
`endif
);

  // The word counter needs one extra bit so it can hold LEN itself.
  localparam int CNT_W = ADDR_W + 1;
  localparam logic [CNT_W-1:0] LEN_C  = CNT_W'(LEN);
  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(LEN - 1);
  localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);

  state_t            state;
  state_t            state_nx;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nx;
  logic [ADDR_W-1:0] ptr_nx;
  logic              last_beat;

  // Data paths are pure pass-throughs; the controller only steers strobes.
  assign fifo_data_i = in_data;
  assign out_data    = fifo_data_o;

  // The FIFO is held clear for the whole reset, so a reset mid-drain
  // discards the partially streamed block.
  assign fifo_clr = (state == CLEAR) | ~reset;

  // The read pointer sits on the final stored word of the current block.
  assign last_beat = ({1'b0, fifo_read_ptr} == (cnt - ONE_C));

`ifdef BLKCTRL_LAST_EN
  assign out_last = out_valid & last_beat;
`endif

  // State, word count and read pointer registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= FILL;
      cnt           <= '0;
      fifo_read_ptr <= '0;
    end else begin
      state         <= state_nx;
      cnt           <= cnt_nx;
      fifo_read_ptr <= ptr_nx;
    end
  end

  // Next-state and output decode for the fill/drain/clear sequence.
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    ptr_nx     = fifo_read_ptr;
    in_ready   = 1'b0;
    fifo_write = 1'b0;
    out_valid  = 1'b0;
    block_done = 1'b0;
    busy       = 1'b1;

    case (state)
      FILL: begin
        busy       = 1'b0;
        in_ready   = fifo_ready & (cnt < LEN_C);
        fifo_write = in_write & in_ready;
        if (fifo_write) begin
          cnt_nx = cnt + ONE_C;
        end
        // A write landing on the final slot closes the block; otherwise a
        // flush closes it as long as it holds at least one word, counting
        // any write accepted in the same cycle.
        if (fifo_write && (cnt == LAST_C)) begin
          state_nx = DRAIN;
        end else if (flush_req && ((cnt != '0) || fifo_write)) begin
          state_nx = DRAIN;
        end
      end

      DRAIN: begin
        out_valid = 1'b1;
        if (out_ready) begin
          // The pointer is not advanced past the final word so it never
          // exceeds LEN-1; CLEAR returns it to zero.
          if (last_beat) begin
            state_nx = CLEAR;
          end else begin
            ptr_nx = fifo_read_ptr + ADDR_W'(1);
          end
        end
      end

      CLEAR: begin
        block_done = 1'b1;
        cnt_nx     = '0;
        ptr_nx     = '0;
        state_nx   = FILL;
      end

      default: begin
        cnt_nx   = '0;
        ptr_nx   = '0;
        state_nx = FILL;
      end
    endcase
  end

endmodule : blockfifo_ctrl

`default_nettype wire

// File: tb/tb_blockfifo_ctrl.sv
// ============================================================================
// Module      : tb_blockfifo_ctrl
// Description : Directed self-checking bench for blockfifo_ctrl with a small
//               behavioural block FIFO attached. Covers the out_last output
//               when BLKCTRL_LAST_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_blockfifo_ctrl;

  localparam int LEN    = 8;
  localparam int WID    = 8;
  localparam int ADDR_W = 3;

  logic              clk;
  logic              reset;
  logic              in_write;
  logic [WID-1:0]    in_data;
  logic              in_ready;
  logic              flush_req;
  logic              fifo_write;
  logic [WID-1:0]    fifo_data_i;
  logic              fifo_ready;
  logic              fifo_clr;
  logic [ADDR_W-1:0] fifo_read_ptr;
  logic [WID-1:0]    fifo_data_o;
  logic [WID-1:0]    out_data;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic              block_done;
`ifdef BLKCTRL_LAST_EN
  logic              out_last;
`endif

  int vectors = 0;
  int errors  = 0;

  blockfifo_ctrl #(.LEN(LEN), .WID(WID)) dut (
    .clk           (clk),
    .reset         (reset),
    .in_write      (in_write),
    .in_data       (in_data),
    .in_ready      (in_ready),
    .flush_req     (flush_req),
    .fifo_write    (fifo_write),
    .fifo_data_i   (fifo_data_i),
    .fifo_ready    (fifo_ready),
    .fifo_clr      (fifo_clr),
    .fifo_read_ptr (fifo_read_ptr),
    .fifo_data_o   (fifo_data_o),
    .out_data      (out_data),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .busy          (busy),
    .block_done    (block_done)
`ifdef BLKCTRL_LAST_EN
    ,
    .out_last      (out_last)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural block FIFO: write pointer cleared by fifo_clr, asynchronous
  // read addressed by the controller.
  logic [WID-1:0] mem [LEN];
  logic [3:0]     wr_idx;

  always @(posedge clk) begin
    if (fifo_clr) begin
      wr_idx <= '0;
    end else if (fifo_write) begin
      mem[wr_idx[ADDR_W-1:0]] <= fifo_data_i;
      wr_idx <= wr_idx + 4'd1;
    end
  end

  assign fifo_data_o = mem[fifo_read_ptr];

  // Global guard so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance one clock; inputs are then changed 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; in_write = 1'b0; in_data = '0; flush_req = 1'b0;
    fifo_ready = 1'b1; out_ready = 1'b0;
    #2;
    vectors++; if (fifo_clr !== 1'b1) begin errors++; $display("FAIL rst_clr: got %b want 1", fifo_clr); end
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %b want 0", out_valid); end
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    vectors++; if (block_done !== 1'b0) begin errors++; $display("FAIL rst_done: got %b want 0", block_done); end
    step(); step();
    vectors++; if (fifo_read_ptr !== 3'd0) begin errors++; $display("FAIL rst_ptr: got %0d want 0", fifo_read_ptr); end
    reset = 1'b1;
    #1;
    vectors++; if (fifo_clr !== 1'b0) begin errors++; $display("FAIL rel_clr: got %b want 0", fifo_clr); end
    vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rel_ready: got %b want 1", in_ready); end
    step();
  endtask

  task automatic test_full_block();
    for (int i = 0; i < LEN; i++) begin
      in_write = 1'b1; in_data = 8'h10 + 8'(i);
      #1;
      vectors++; if (fifo_write !== 1'b1) begin errors++; $display("FAIL full_wr[%0d]: got %b want 1", i, fifo_write); end
      vectors++; if (fifo_data_i !== 8'h10 + 8'(i)) begin errors++; $display("FAIL full_din[%0d]: got %h want %h", i, fifo_data_i, 8'h10 + 8'(i)); end
      step();
    end
    in_write = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < LEN; i++) begin
      #1;
      vectors++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_rdy_drain[%0d]: got %b want 0", i, in_ready); end
      vectors++; if (out_valid !== 1'b1) begin errors++; $display("FAIL full_valid[%0d]: got %b want 1", i, out_valid); end
      vectors++; if (out_data !== 8'h10 + 8'(i)) begin errors++; $display("FAIL full_data[%0d]: got %h want %h", i, out_data, 8'h10 + 8'(i)); end
      vectors++; if (fifo_read_ptr !== 3'(i)) begin errors++; $display("FAIL full_ptr[%0d]: got %0d want %0d", i, fifo_read_ptr, i); end
      vectors++; if (block_done !== 1'b0) begin errors++; $display("FAIL full_done_early[%0d]: got %b want 0", i, block_done); end
      step();
    end
    #1;
    vectors++; if (block_done !== 1'b1) begin errors++; $display("FAIL full_done: got %b want 1", block_done); end
    vectors++; if (fifo_clr !== 1'b1) begin errors++; $display("FAIL full_clr: got %b want 1", fifo_clr); end
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL full_clr_valid: got %b want 0", out_valid); end
    vectors++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_clr_rdy: got %b want 0", in_ready); end
    step();
    #1;
    vectors++; if (block_done !== 1'b0) begin errors++; $display("FAIL full_done_once: got %b want 0", block_done); end
    vectors++; if (fifo_clr !== 1'b0) begin errors++; $display("FAIL full_clr_once: got %b want 0", fifo_clr); end
    vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL full_rdy_back: got %b want 1", in_ready); end
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL full_busy_back: got %b want 0", busy); end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 3; i++) begin
      in_write = 1'b1; in_data = 8'hA0 + 8'(i);
      step();
    end
    in_write = 1'b0; flush_req = 1'b1;
    #1;
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy_pre: got %b want 0", busy); end
    step();
    flush_req = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++; if (out_valid !== 1'b1) begin errors++; $display("FAIL flush_valid[%0d]: got %b want 1", i, out_valid); end
      vectors++; if (out_data !== 8'hA0 + 8'(i)) begin errors++; $display("FAIL flush_data[%0d]: got %h want %h", i, out_data, 8'hA0 + 8'(i)); end
      vectors++; if (fifo_read_ptr !== 3'(i)) begin errors++; $display("FAIL flush_ptr[%0d]: got %0d want %0d", i, fifo_read_ptr, i); end
`ifdef BLKCTRL_LAST_EN
      vectors++; if (out_last !== (i == 2)) begin errors++; $display("FAIL flush_last[%0d]: got %b want %b", i, out_last, (i == 2)); end
`endif
      step();
    end
    #1;
    vectors++; if (block_done !== 1'b1) begin errors++; $display("FAIL flush_done: got %b want 1", block_done); end
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_clr_valid: got %b want 0", out_valid); end
    step();
    #1;
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL flush_busy_post: got %b want 0", busy); end
    vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_rdy_post: got %b want 1", in_ready); end
  endtask

  task automatic test_empty_flush();
    flush_req = 1'b1; in_write = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL eflush_busy[%0d]: got %b want 0", i, busy); end
      vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL eflush_valid[%0d]: got %b want 0", i, out_valid); end
      step();
    end
    flush_req = 1'b0;
    #1;
    vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL eflush_rdy: got %b want 1", in_ready); end
  endtask

  task automatic test_backpressure();
    logic [3:0] pat;
    int idx;
    int guard;
    pat = 4'b1001;
    for (int i = 0; i < LEN; i++) begin
      in_write = 1'b1; in_data = 8'h30 + 8'(i);
      step();
    end
    in_write = 1'b0;
    idx = 0; guard = 0;
    while (idx < LEN && guard < 40) begin
      out_ready = pat[guard % 4];
      #1;
      vectors++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %b want 1", guard, out_valid); end
      vectors++; if (out_data !== 8'h30 + 8'(idx)) begin errors++; $display("FAIL bp_data[%0d]: got %h want %h", guard, out_data, 8'h30 + 8'(idx)); end
      vectors++; if (fifo_read_ptr !== 3'(idx)) begin errors++; $display("FAIL bp_ptr[%0d]: got %0d want %0d", guard, fifo_read_ptr, idx); end
      if (out_ready) idx++;
      guard++;
      step();
    end
    vectors++; if (idx != LEN) begin errors++; $display("FAIL bp_timeout: got %0d beats want %0d", idx, LEN); end
    out_ready = 1'b1;
    #1;
    vectors++; if (block_done !== 1'b1) begin errors++; $display("FAIL bp_done: got %b want 1", block_done); end
    step();
  endtask

  task automatic test_reset_mid_drain();
    for (int i = 0; i < LEN; i++) begin
      in_write = 1'b1; in_data = 8'h50 + 8'(i);
      step();
    end
    in_write = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 4; i++) step();
    #1;
    vectors++; if (fifo_read_ptr !== 3'd4) begin errors++; $display("FAIL mrst_ptr_pre: got %0d want 4", fifo_read_ptr); end
    vectors++; if (out_data !== 8'h54) begin errors++; $display("FAIL mrst_data_pre: got %h want 54", out_data); end
    reset = 1'b0;
    #1;
    vectors++; if (fifo_clr !== 1'b1) begin errors++; $display("FAIL mrst_clr: got %b want 1", fifo_clr); end
    vectors++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mrst_valid: got %b want 0", out_valid); end
    vectors++; if (fifo_read_ptr !== 3'd0) begin errors++; $display("FAIL mrst_ptr: got %0d want 0", fifo_read_ptr); end
    step();
    reset = 1'b1;
    #1;
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL mrst_busy: got %b want 0", busy); end
    vectors++; if (in_ready !== 1'b1) begin errors++; $display("FAIL mrst_rdy: got %b want 1", in_ready); end
    step();
    for (int i = 0; i < LEN; i++) begin
      in_write = 1'b1; in_data = 8'h60 + 8'(i);
      step();
    end
    in_write = 1'b0;
    for (int i = 0; i < LEN; i++) begin
      #1;
      vectors++; if (out_data !== 8'h60 + 8'(i)) begin errors++; $display("FAIL mrst_next[%0d]: got %h want %h", i, out_data, 8'h60 + 8'(i)); end
      step();
    end
    #1;
    vectors++; if (block_done !== 1'b1) begin errors++; $display("FAIL mrst_done: got %b want 1", block_done); end
    step();
  endtask

  task automatic test_flush_with_write();
    for (int i = 0; i < 5; i++) begin
      in_write = 1'b1; in_data = 8'h70 + 8'(i);
      step();
    end
    in_data = 8'h75; flush_req = 1'b1;
    #1;
    vectors++; if (fifo_write !== 1'b1) begin errors++; $display("FAIL fw_write: got %b want 1", fifo_write); end
    step();
    flush_req = 1'b0; in_data = 8'hEE; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      vectors++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fw_rdy[%0d]: got %b want 0", i, in_ready); end
      vectors++; if (fifo_write !== 1'b0) begin errors++; $display("FAIL fw_wr[%0d]: got %b want 0", i, fifo_write); end
      vectors++; if (out_data !== 8'h70 + 8'(i)) begin errors++; $display("FAIL fw_data[%0d]: got %h want %h", i, out_data, 8'h70 + 8'(i)); end
`ifdef BLKCTRL_LAST_EN
      vectors++; if (out_last !== (i == 5)) begin errors++; $display("FAIL fw_last[%0d]: got %b want %b", i, out_last, (i == 5)); end
`endif
      step();
    end
    in_write = 1'b0;
    #1;
    vectors++; if (block_done !== 1'b1) begin errors++; $display("FAIL fw_done: got %b want 1", block_done); end
    step();
  endtask

  initial begin
    test_reset();
    test_full_block();
    test_flush();
    test_empty_flush();
    test_backpressure();
    test_reset_mid_drain();
    test_flush_with_write();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule : tb_blockfifo_ctrl

`default_nettype wire
